swap_rsp_tracker: RTL and testbench
===================================

Name: swap_rsp_tracker

Overview:
- Companion to the region-match swap logic in the AXI node: the swap redirects an initiator's request so it is presented as a different initiator port; this block is the return path.
- Records, per request, the original and presented initiator index, then steers the returning response beats back to the original initiator.
- Sits between one slave-side request/response channel pair and the node's per-initiator response outputs.
- Responses on the channel are in order, so tracking is a single in-order FIFO.

Parameters:
- N_INIT_PORT, 8, number of initiator ports.
- LOG_N_INIT, 3, index width; must equal clog2(N_INIT_PORT).
- DEPTH, 4, maximum outstanding transactions; must be a power of 2, at least 2.
- LOG_DEPTH, 2, clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- select_i  in  N_INIT_PORT  per-initiator swap enable.
- target_i  in  N_INIT_PORT x LOG_N_INIT  per-initiator presented index when swapped.
- req_valid_i  in  1  request from the node.
- req_init_i  in  LOG_N_INIT  originating initiator.
- req_ready_o  out  1  request accepted.
- req_valid_o  out  1  request to slave.
- req_init_o  out  LOG_N_INIT  presented initiator index.
- req_ready_i  in  1  slave ready.
- rsp_valid_i  in  1  response beat from slave.
- rsp_last_i  in  1  final beat of the transaction.
- rsp_dst_i  in  LOG_N_INIT  presented index carried by the response.
- rsp_ready_o  out  1  beat accepted.
- rsp_valid_o  out  N_INIT_PORT  one-hot valid to the original initiator.
- rsp_ready_i  in  N_INIT_PORT  per-initiator ready.
- occ_o  out  LOG_DEPTH+1  outstanding count.

Behaviour:
- Reset: FIFO empty, occ_o=0, rsp_valid_o=0. req_valid_o, req_ready_o and rsp_ready_o are forced to 0 while rst is asserted.
- Presented index:
  - If select_i[req_init_i] is 1, presented = target_i[req_init_i].
  - Otherwise presented = req_init_i.
  - req_init_o drives the presented index combinationally.
- Request path:
  - full = (occ_o == DEPTH).
  - req_valid_o = req_valid_i & !full.
  - req_ready_o = req_ready_i & !full.
- Push: on req_valid_i & req_ready_o, write {orig = req_init_i, pres = presented} at the write pointer. Every request is pushed, swapped or not, so order is preserved.
- Response path, FIFO non-empty:
  - rsp_valid_o[head.orig] = rsp_valid_i; all other bits are 0.
  - rsp_ready_o = rsp_ready_i[head.orig].
  - No combinational dependency on rsp_dst_i for routing; routing uses head.orig only.
- Pop: on rsp_valid_i & rsp_ready_o & rsp_last_i. Non-last beats do not pop.
- Minimum latency: an entry is visible to the response path the cycle after its push. There is no same-cycle bypass.
- Simultaneous push and pop: occ_o is unchanged and both pointers advance.
- Full: a push is refused even if a pop happens in the same cycle; acceptance is decided on the registered occ_o.
- Empty with rsp_valid_i high (orphan response): see Optional Feature.
- Pointers are LOG_DEPTH bits and wrap naturally; occ_o saturates neither direction. Overflow and underflow are prevented by the rules above.
- Reset mid-transaction: all outstanding entries are discarded and any in-flight response beats are not routed.
- select_i and target_i are sampled only at push. Changing them has no effect on entries already queued.

Optional Feature:
- Macro: SWAP_RSP_CHECK_EN.
- When defined, adds output err_o (1 bit, reset 0, sticky until rst). err_o sets when:
  - rsp_valid_i arrives with the FIFO empty. The beat is dropped: rsp_ready_o=1, rsp_valid_o=0.
  - rsp_valid_i arrives with rsp_dst_i != head.pres. The beat is still routed to head.orig.
- When not defined: no err_o port. An orphan response is stalled (rsp_ready_o=0, rsp_valid_o=0) until an entry exists. rsp_dst_i is unused.

Decomposition:
- Package swap_pkg holds the entry typedef {orig, pres} as a packed struct of LOG_N_INIT-wide fields, and an init_idx_t typedef.
- One sub-module: swap_rsp_fifo, a generic DEPTH-entry sync FIFO with push, pop, full, empty, count and head data. The top adds the index selection and one-hot steering.

Test Plan:
- select_i[2]=1, target_i[2]=5; request from init 2 -> req_init_o=5. A 3-beat response with last on beat 3 -> rsp_valid_o=8'b0000_0100 on all beats, pop after beat 3, occ_o 1->0.
- Unswapped requests from inits 1, 3, 6 back to back -> occ_o=3. Three single-beat responses -> rsp_valid_o = 0x02, 0x08, 0x40 in order.
- 4 requests with DEPTH=4 -> occ_o=4, req_ready_o=0 on the 5th even with a pop that cycle. It is accepted the next cycle.
- occ_o=2 with push and last-beat pop in the same cycle -> occ_o stays 2, head advances. Fill and drain 9 times to cover pointer wrap.
- Response with FIFO empty -> without the macro, rsp_ready_o=0 and it stalls until a request is pushed. With SWAP_RSP_CHECK_EN, the beat is dropped and err_o=1.
- rst asserted with occ_o=3 mid-burst -> occ_o=0 and rsp_valid_o=0 immediately (asynchronously). After release, a new request/response routes correctly.

Source files
------------

// File: rtl/swap_pkg.sv
// Shared types for the swap response tracker: initiator index and the
// per-transaction tracking entry {orig, pres}.
package swap_pkg;

  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] init_idx_t;

  typedef struct packed {
    init_idx_t orig;
    init_idx_t pres;
  } entry_t;

endpackage

// File: rtl/swap_rsp_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered head, count and
// full/empty flags; no same-cycle bypass from push to head.
module swap_rsp_fifo #(
  parameter int unsigned W         = 6,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count,
  output logic [W-1:0]       head
);

  logic [W-1:0]         mem [DEPTH];
  logic [LOG_DEPTH-1:0] wptr;
  logic [LOG_DEPTH-1:0] rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + LOG_DEPTH'(1);
      if (pop)  rptr <= rptr + LOG_DEPTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (LOG_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG_DEPTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign full  = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

endmodule

// File: rtl/swap_rsp_tracker.sv
// Return path of the region-match swap: remembers original/presented initiator
// per request and steers in-order responses back to the original initiator.
// Optional build macro SWAP_RSP_CHECK_EN adds sticky err_o and drops orphans.
module swap_rsp_tracker
  import swap_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned LOG_N_INIT  = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LOG_DEPTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_INIT_PORT-1:0]                select_i,
  input  logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] target_i,
  input  logic                                  req_valid_i,
  input  logic [LOG_N_INIT-1:0]                 req_init_i,
  output logic                                  req_ready_o,
  output logic                                  req_valid_o,
  output logic [LOG_N_INIT-1:0]                 req_init_o,
  input  logic                                  req_ready_i,
  input  logic                                  rsp_valid_i,
  input  logic                                  rsp_last_i,
  input  logic [LOG_N_INIT-1:0]                 rsp_dst_i,
  output logic                                  rsp_ready_o,
  output logic [N_INIT_PORT-1:0]                rsp_valid_o,
  input  logic [N_INIT_PORT-1:0]                rsp_ready_i,
  output logic [LOG_DEPTH:0]                    occ_o
`ifdef SWAP_RSP_CHECK_EN
  ,
  output logic                                  err_o
`endif
);

  localparam int unsigned EW = $bits(entry_t);

  entry_t          push_entry;
  entry_t          head;
  logic [EW-1:0]   head_raw;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [LOG_N_INIT-1:0] presented;

  // Swap lookup is sampled only here, at push time.
  always_comb begin
    presented = req_init_i;
    if (select_i[req_init_i]) presented = target_i[req_init_i];
  end

  assign req_init_o  = presented;
  assign req_valid_o = !rst && req_valid_i && !full;
  assign req_ready_o = !rst && req_ready_i && !full;
  assign push        = req_valid_i && req_ready_o;

  assign push_entry.orig = init_idx_t'(req_init_i);
  assign push_entry.pres = init_idx_t'(presented);
  assign head            = entry_t'(head_raw);

  // Routing follows head.orig only; the carried rsp_dst_i is never used to steer.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    if (!rst) begin
      if (!empty) begin
        rsp_valid_o[head.orig] = rsp_valid_i;
        rsp_ready_o            = rsp_ready_i[head.orig];
      end else begin
`ifdef SWAP_RSP_CHECK_EN
        rsp_ready_o = 1'b1;
`else
        rsp_ready_o = 1'b0;
`endif
      end
    end
  end

  assign pop = rsp_valid_i && rsp_ready_o && rsp_last_i && !empty;

  swap_rsp_fifo #(
    .W         (EW),
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (EW'(push_entry)),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (occ_o),
    .head  (head_raw)
  );

`ifdef SWAP_RSP_CHECK_EN
  // Sticky flag for orphan beats and presented-index mismatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (rsp_valid_i && (empty || (rsp_dst_i != LOG_N_INIT'(head.pres)))) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_c;
  assign unused_c = ^{rsp_dst_i, head.pres};
`endif

endmodule

// File: tb/tb_swap_rsp_tracker.sv
// Scoreboard bench for swap_rsp_tracker: stimulus queues expected presented
// indices and one-hot response vectors; a negedge monitor pops and compares.
module tb_swap_rsp_tracker;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      select_i;
  logic [7:0][2:0] target_i;
  logic            req_valid_i;
  logic [2:0]      req_init_i;
  logic            req_ready_o;
  logic            req_valid_o;
  logic [2:0]      req_init_o;
  logic            req_ready_i;
  logic            rsp_valid_i;
  logic            rsp_last_i;
  logic [2:0]      rsp_dst_i;
  logic            rsp_ready_o;
  logic [7:0]      rsp_valid_o;
  logic [7:0]      rsp_ready_i;
  logic [2:0]      occ_o;
`ifdef SWAP_RSP_CHECK_EN
  logic            err_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] req_q [$];
  logic [7:0] rsp_q [$];

  always #5 clk = ~clk;

  swap_rsp_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .select_i    (select_i),
    .target_i    (target_i),
    .req_valid_i (req_valid_i),
    .req_init_i  (req_init_i),
    .req_ready_o (req_ready_o),
    .req_valid_o (req_valid_o),
    .req_init_o  (req_init_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_last_i  (rsp_last_i),
    .rsp_dst_i   (rsp_dst_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .occ_o       (occ_o)
`ifdef SWAP_RSP_CHECK_EN
    ,
    .err_o       (err_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every accepted request and every routed response beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid_i && req_ready_o) begin
        if (req_q.size() == 0) chk("req_unexpected", 32'(req_init_o), 32'hffff);
        else chk("req_init_o", 32'(req_init_o), 32'(req_q.pop_front()));
      end
      if ((|rsp_valid_o) && rsp_ready_o) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_o), 32'hffff);
        else chk("rsp_valid_o", 32'(rsp_valid_o), 32'(rsp_q.pop_front()));
      end
    end
  end

  task automatic send_req(input logic [2:0] init, input logic [2:0] pres);
    req_q.push_back(pres);
    req_valid_i = 1'b1;
    req_init_i  = init;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic last, input logic [2:0] dst, input logic [7:0] exp);
    logic ok;
    ok = 1'b0;
    rsp_q.push_back(exp);
    rsp_valid_i = 1'b1;
    rsp_last_i  = last;
    rsp_dst_i   = dst;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_ready_o) ok = 1'b1;
    end
    chk("beat_accepted", 32'(ok), 32'd1);
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    select_i    = '0;
    target_i    = '0;
    req_valid_i = 1'b1;
    req_init_i  = 3'd0;
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    rsp_dst_i   = 3'd0;
    rsp_ready_i = 8'hff;

    // Reset state with request inputs active.
    at_neg();
    chk("rst_occ", 32'(occ_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready_o), 32'd0);
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Swapped request 2 -> 5, three-beat response back to init 2.
    select_i[2] = 1'b1;
    target_i[2] = 3'd5;
    send_req(3'd2, 3'd5);
    chk("t1_occ_push", 32'(occ_o), 32'd1);
    target_i[2] = 3'd7;
    send_beat(1'b0, 3'd5, 8'h04);
    chk("t1_occ_b1", 32'(occ_o), 32'd1);
    send_beat(1'b0, 3'd5, 8'h04);
    chk("t1_occ_b2", 32'(occ_o), 32'd1);
    send_beat(1'b1, 3'd5, 8'h04);
    chk("t1_occ_b3", 32'(occ_o), 32'd0);
    select_i = '0;
    target_i = '0;

    // Unswapped back-to-back requests.
    send_req(3'd1, 3'd1);
    send_req(3'd3, 3'd3);
    send_req(3'd6, 3'd6);
    chk("t2_occ", 32'(occ_o), 32'd3);
    send_beat(1'b1, 3'd1, 8'h02);
    send_beat(1'b1, 3'd3, 8'h08);
    send_beat(1'b1, 3'd6, 8'h40);
    chk("t2_occ_drain", 32'(occ_o), 32'd0);

    // Full: fifth request refused even with a pop that cycle.
    for (int k = 0; k < 4; k++) send_req(3'(k), 3'(k));
    chk("t3_occ_full", 32'(occ_o), 32'd4);
    req_q.push_back(3'd7);
    rsp_q.push_back(8'h01);
    req_valid_i = 1'b1;
    req_init_i  = 3'd7;
    rsp_valid_i = 1'b1;
    rsp_last_i  = 1'b1;
    rsp_dst_i   = 3'd0;
    at_neg();
    chk("t3_ready_full", 32'(req_ready_o), 32'd0);
    chk("t3_valid_full", 32'(req_valid_o), 32'd0);
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    at_neg();
    chk("t3_ready_next", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("t3_occ_refill", 32'(occ_o), 32'd4);
    send_beat(1'b1, 3'd1, 8'h02);
    send_beat(1'b1, 3'd2, 8'h04);
    send_beat(1'b1, 3'd3, 8'h08);
    send_beat(1'b1, 3'd7, 8'h80);

    // Simultaneous push and last-beat pop at occ 2.
    send_req(3'd1, 3'd1);
    send_req(3'd2, 3'd2);
    req_q.push_back(3'd5);
    rsp_q.push_back(8'h02);
    req_valid_i = 1'b1;
    req_init_i  = 3'd5;
    rsp_valid_i = 1'b1;
    rsp_last_i  = 1'b1;
    rsp_dst_i   = 3'd1;
    at_neg();
    chk("t4_occ_pre", 32'(occ_o), 32'd2);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    chk("t4_occ_post", 32'(occ_o), 32'd2);
    send_beat(1'b1, 3'd2, 8'h04);
    send_beat(1'b1, 3'd5, 8'h20);
    chk("t4_occ_empty", 32'(occ_o), 32'd0);

    // Fill/drain nine times to wrap the pointers.
    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < 4; k++) send_req(3'((r + k) % 8), 3'((r + k) % 8));
      chk("wrap_full", 32'(occ_o), 32'd4);
      for (int k = 0; k < 4; k++)
        send_beat(1'b1, 3'((r + k) % 8), 8'(8'd1 << ((r + k) % 8)));
      chk("wrap_empty", 32'(occ_o), 32'd0);
    end

    // Orphan response with the FIFO empty.
`ifdef SWAP_RSP_CHECK_EN
    rsp_valid_i = 1'b1;
    rsp_last_i  = 1'b1;
    rsp_dst_i   = 3'd4;
    at_neg();
    chk("orph_ready", 32'(rsp_ready_o), 32'd1);
    chk("orph_valid", 32'(rsp_valid_o), 32'd0);
    chk("orph_err_pre", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    at_neg();
    chk("orph_err", 32'(err_o), 32'd1);
    chk("orph_occ", 32'(occ_o), 32'd0);
    @(posedge clk); #1;
`else
    rsp_q.push_back(8'h10);
    rsp_valid_i = 1'b1;
    rsp_last_i  = 1'b1;
    rsp_dst_i   = 3'd4;
    at_neg();
    chk("orph_ready0", 32'(rsp_ready_o), 32'd0);
    chk("orph_valid0", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    at_neg();
    chk("orph_ready1", 32'(rsp_ready_o), 32'd0);
    @(posedge clk); #1;
    req_q.push_back(3'd4);
    req_valid_i = 1'b1;
    req_init_i  = 3'd4;
    at_neg();
    chk("orph_nobypass", 32'(rsp_ready_o), 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    at_neg();
    chk("orph_occ1", 32'(occ_o), 32'd1);
    chk("orph_routed", 32'(rsp_ready_o), 32'd1);
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
    at_neg();
    chk("orph_occ0", 32'(occ_o), 32'd0);
    @(posedge clk); #1;
`endif

    // Asynchronous reset mid-burst with three outstanding entries.
    send_req(3'd1, 3'd1);
    send_req(3'd2, 3'd2);
    send_req(3'd3, 3'd3);
    send_beat(1'b0, 3'd1, 8'h02);
    rsp_valid_i = 1'b1;
    rsp_dst_i   = 3'd1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_occ", 32'(occ_o), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("arst_rsp_ready", 32'(rsp_ready_o), 32'd0);
    rsp_valid_i = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    select_i[6] = 1'b1;
    target_i[6] = 3'd0;
    send_req(3'd6, 3'd0);
    send_beat(1'b1, 3'd0, 8'h40);
    chk("post_rst_occ", 32'(occ_o), 32'd0);
`ifdef SWAP_RSP_CHECK_EN
    chk("post_rst_err", 32'(err_o), 32'd0);
`endif

    @(posedge clk); #1;
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
